// File: rtl/bus_master.sv
// bus_master: 68000-style AS/UDS/LDS bus initiator that turns one word request into a full bus cycle,
// ending on DTACK, BERR or an internal wait-state timeout.
module bus_master #(
    parameter int TIMEOUT = 64,
    parameter int ADDR_W  = 23
) (
    input  logic              clk_in,
    input  logic              reset,
    input  logic              req,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_be,
    input  logic [15:0]       req_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              tmo,
    output logic [15:0]       rdata,
    output logic [ADDR_W-1:0] a_out,
    output logic              as_n,
    output logic              uds_n,
    output logic              lds_n,
    output logic              rw,
    output logic [15:0]       d_out,
    output logic              d_oe,
    input  logic [15:0]       d_in,
    input  logic              dtack_n,
    input  logic              berr_n
);
    typedef enum logic [2:0] {IDLE, ADDR, ASRT, WAIT, LATCH, END} state_t;
    state_t state, state_d;
    logic [1:0] be, be_d;
    logic [7:0] cnt, cnt_d;
    logic busy_d, done_d, err_d, tmo_d, as_d, uds_d, lds_d, rw_d, oe_d;
    logic [ADDR_W-1:0] a_d;
    logic [15:0] dout_d, rdata_d;
    // Next-state values for every output; the register block below makes them all flop outputs.
    always_comb begin
        state_d = state;
        be_d = be;
        cnt_d = cnt;
        busy_d = busy;
        done_d = 1'b0;
        err_d = err;
        tmo_d = tmo;
        as_d = as_n;
        uds_d = uds_n;
        lds_d = lds_n;
        rw_d = rw;
        oe_d = d_oe;
        a_d = a_out;
        dout_d = d_out;
        rdata_d = rdata;
        case (state)
            IDLE: if (req && |req_be && dtack_n && berr_n) begin
                state_d = ADDR;
                be_d = req_be;
                busy_d = 1'b1;
                a_d = req_addr;
                rw_d = req_rw;
                dout_d = req_wdata;
                oe_d = !req_rw;
            end
            ADDR: begin
                state_d = ASRT;
                as_d = 1'b0;
                uds_d = !(rw && be[1]);
                lds_d = !(rw && be[0]);
            end
            ASRT: begin
                state_d = WAIT;
                cnt_d = 8'd0;
                uds_d = !be[1];
                lds_d = !be[0];
            end
            WAIT: if (!berr_n || (dtack_n && cnt == 8'(TIMEOUT - 1))) begin
                state_d = END;
                done_d = 1'b1;
                err_d = 1'b1;
                tmo_d = berr_n;
                as_d = 1'b1;
                uds_d = 1'b1;
                lds_d = 1'b1;
            end else if (!dtack_n) begin
                state_d = LATCH;
            end else begin
                cnt_d = cnt + 8'd1;
            end
            LATCH: begin
                state_d = END;
                done_d = 1'b1;
                err_d = 1'b0;
                tmo_d = 1'b0;
                as_d = 1'b1;
                uds_d = 1'b1;
                lds_d = 1'b1;
                rdata_d = rw ? {be[1] ? d_in[15:8] : rdata[15:8], be[0] ? d_in[7:0] : rdata[7:0]} : rdata;
            end
            END: begin
                state_d = IDLE;
                busy_d = 1'b0;
                oe_d = 1'b0;
                rw_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state <= IDLE;
            be <= 2'b00;
            cnt <= 8'd0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
            tmo <= 1'b0;
            as_n <= 1'b1;
            uds_n <= 1'b1;
            lds_n <= 1'b1;
            rw <= 1'b1;
            d_oe <= 1'b0;
            a_out <= '0;
            d_out <= 16'h0;
            rdata <= 16'h0;
        end else begin
            state <= state_d;
            be <= be_d;
            cnt <= cnt_d;
            busy <= busy_d;
            done <= done_d;
            err <= err_d;
            tmo <= tmo_d;
            as_n <= as_d;
            uds_n <= uds_d;
            lds_n <= lds_d;
            rw <= rw_d;
            d_oe <= oe_d;
            a_out <= a_d;
            d_out <= dout_d;
            rdata <= rdata_d;
        end
    end
endmodule

// File: tb/tb_bus_master.sv
// tb_bus_master: table-driven bus cycles plus hand sequences for reset, timeout, stuck DTACK and mid-cycle reset.
module tb_bus_master;
    logic clk_in = 1'b0;
    logic reset, req, req_rw, dtack_n, berr_n;
    logic [22:0] req_addr;
    logic [1:0] req_be;
    logic [15:0] req_wdata, d_in;
    logic busy, done, err, tmo, as_n, uds_n, lds_n, rw, d_oe;
    logic [15:0] rdata, d_out;
    logic [22:0] a_out;
    int checks = 0;
    int errors = 0;
    string cur = "";

    bus_master dut (
        .clk_in(clk_in), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
        .req_be(req_be), .req_wdata(req_wdata), .busy(busy), .done(done), .err(err), .tmo(tmo),
        .rdata(rdata), .a_out(a_out), .as_n(as_n), .uds_n(uds_n), .lds_n(lds_n), .rw(rw),
        .d_out(d_out), .d_oe(d_oe), .d_in(d_in), .dtack_n(dtack_n), .berr_n(berr_n)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rw;
        logic [22:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
        int          waits;
        logic        berr;
        logic [15:0] din;
        logic [15:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %0h expected %0h", cur, name, act, exp);
        end
    endtask

    // Called and returns on a negedge while the DUT is idle.
    task automatic run_txn(input vec_t v);
        req = 1'b1;
        req_rw = v.rw;
        req_addr = v.addr;
        req_be = v.be;
        req_wdata = v.wdata;
        dtack_n = 1'b1;
        berr_n = 1'b1;
        d_in = 16'h0;
        @(negedge clk_in);
        req = 1'b0;
        chk("busy_addr", busy, 1);
        chk("as_addr", as_n, 1);
        chk("uds_addr", uds_n, 1);
        chk("a_out", a_out, v.addr);
        chk("rw_addr", rw, v.rw);
        chk("d_oe_addr", d_oe, !v.rw);
        if (!v.rw) chk("d_out", d_out, v.wdata);
        @(negedge clk_in);
        chk("as_asrt", as_n, 0);
        chk("uds_asrt", uds_n, !(v.rw && v.be[1]));
        chk("lds_asrt", lds_n, !(v.rw && v.be[0]));
        for (int i = 0; i <= v.waits; i++) begin
            @(negedge clk_in);
            chk("as_wait", as_n, 0);
            chk("uds_wait", uds_n, !v.be[1]);
            chk("lds_wait", lds_n, !v.be[0]);
            chk("done_wait", done, 0);
            if (i == v.waits) begin
                dtack_n = 1'b0;
                berr_n = !v.berr;
                d_in = v.din;
            end
        end
        @(negedge clk_in);
        if (!v.berr) begin
            chk("as_latch", as_n, 0);
            chk("done_latch", done, 0);
            dtack_n = 1'b1;
            @(negedge clk_in);
        end else begin
            dtack_n = 1'b1;
            berr_n = 1'b1;
        end
        chk("done_end", done, 1);
        chk("err_end", err, v.berr);
        chk("tmo_end", tmo, 0);
        chk("as_end", as_n, 1);
        chk("uds_end", uds_n, 1);
        chk("lds_end", lds_n, 1);
        chk("d_oe_end", d_oe, !v.rw);
        chk("rdata_end", rdata, v.exp_rdata);
        @(negedge clk_in);
        chk("done_idle", done, 0);
        chk("busy_idle", busy, 0);
        chk("d_oe_idle", d_oe, 0);
        chk("rw_idle", rw, 1);
        chk("err_hold", err, v.berr);
        chk("rdata_idle", rdata, v.exp_rdata);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        vecs[0] = '{1'b1, 23'h000100, 2'b11, 16'h0000, 0, 1'b0, 16'hBEEF, 16'hBEEF, 1'b0};
        vecs[1] = '{1'b0, 23'h001234, 2'b01, 16'h0055, 3, 1'b0, 16'h0000, 16'hBEEF, 1'b0};
        vecs[2] = '{1'b1, 23'h002000, 2'b01, 16'h0000, 0, 1'b0, 16'h1234, 16'hBE34, 1'b0};
        vecs[3] = '{1'b1, 23'h7FFFFF, 2'b10, 16'h0000, 2, 1'b0, 16'hA5C3, 16'hA534, 1'b0};
        vecs[4] = '{1'b1, 23'h000200, 2'b11, 16'h0000, 0, 1'b1, 16'hFFFF, 16'hA534, 1'b1};
        vecs[5] = '{1'b0, 23'h400000, 2'b11, 16'hCAFE, 1, 1'b0, 16'h0000, 16'hA534, 1'b0};
        vecs[6] = '{1'b0, 23'h000010, 2'b10, 16'h1100, 2, 1'b1, 16'h0000, 16'hA534, 1'b1};
        vecs[7] = '{1'b1, 23'h000020, 2'b11, 16'h0000, 5, 1'b0, 16'h0F0F, 16'h0F0F, 1'b0};
        reset = 1'b0;
        req = 1'b1;
        req_rw = 1'b1;
        req_addr = 23'h000100;
        req_be = 2'b11;
        req_wdata = 16'h0;
        d_in = 16'h0;
        dtack_n = 1'b1;
        berr_n = 1'b1;
        cur = "reset";
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk("as_rst", as_n, 1);
            chk("uds_rst", uds_n, 1);
            chk("lds_rst", lds_n, 1);
            chk("d_oe_rst", d_oe, 0);
            chk("busy_rst", busy, 0);
            chk("done_rst", done, 0);
            chk("rdata_rst", rdata, 0);
        end
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cur = $sformatf("vec%0d", i);
            run_txn(vecs[i]);
        end

        cur = "timeout";
        req = 1'b1;
        req_rw = 1'b1;
        req_addr = 23'h000055;
        req_be = 2'b11;
        @(negedge clk_in);
        req = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_in);
            n++;
            if (done) break;
        end
        chk("cycles", n, 66);
        chk("done", done, 1);
        chk("err", err, 1);
        chk("tmo", tmo, 1);
        chk("as", as_n, 1);
        chk("uds", uds_n, 1);
        chk("lds", lds_n, 1);
        chk("rdata", rdata, 16'h0F0F);
        @(negedge clk_in);
        chk("busy_after", busy, 0);
        chk("tmo_hold", tmo, 1);
        cur = "post_tmo";
        run_txn(vecs[0]);

        cur = "stuck_dtack";
        dtack_n = 1'b0;
        req = 1'b1;
        req_rw = 1'b1;
        req_addr = 23'h000300;
        req_be = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk("busy_stall", busy, 0);
            chk("as_stall", as_n, 1);
        end
        dtack_n = 1'b1;
        @(negedge clk_in);
        chk("busy_accept", busy, 1);
        req = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        chk("as_wait", as_n, 0);
        chk("lds_wait", lds_n, 0);
        cur = "mid_reset";
        reset = 1'b0;
        @(negedge clk_in);
        chk("as", as_n, 1);
        chk("uds", uds_n, 1);
        chk("lds", lds_n, 1);
        chk("busy", busy, 0);
        chk("done", done, 0);
        chk("d_oe", d_oe, 0);
        chk("a_out", a_out, 0);
        chk("rdata", rdata, 0);
        reset = 1'b1;
        @(negedge clk_in);
        chk("done_after", done, 0);
        chk("busy_after", busy, 0);
        cur = "post_reset";
        run_txn(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_master.md
Name: bus_master

Overview:
- Synthesizable 68000-style asynchronous bus initiator for the Raven68k CPLD/FPGA bring-up path.
- Turns a single-word request interface into a full AS/UDS/LDS/R/W bus cycle.
- Exercises the address-decode/glue logic (chip selects, DTACK, BERR generation) from the initiator side, standing in for the CPU on a test fixture or a DMA-style secondary master.
- Terminates each cycle on DTACK, on BERR, or on an internal timeout.

Parameters:
- TIMEOUT, 64, number of WAIT-state cycles without DTACK/BERR before the cycle aborts with a timeout error (range 2..255).
- ADDR_W, 23, address width; drives A[ADDR_W:1].

Ports:
- clk_in  in  1  system clock; every flop uses its rising edge.
- reset  in  1  synchronous, active-low reset.
- req  in  1  request strobe; sampled only in IDLE.
- req_rw  in  1  1 = read, 0 = write.
- req_addr  in  ADDR_W  word address, maps to A[ADDR_W:1].
- req_be  in  2  byte enables: [1] = upper/UDS, [0] = lower/LDS.
- req_wdata  in  16  write data.
- busy  out  1  high from the accept edge until done is pulsed.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = BERR or timeout.
- tmo  out  1  valid with done; 1 = timeout (implies err).
- rdata  out  16  read data, valid from done until the next read completes.
- a_out  out  ADDR_W  bus address A[ADDR_W:1].
- as_n  out  1  address strobe, active low.
- uds_n  out  1  upper data strobe, active low.
- lds_n  out  1  lower data strobe, active low.
- rw  out  1  bus R/W (1 = read).
- d_out  out  16  bus write data.
- d_oe  out  1  data-bus output enable.
- d_in  in  16  bus read data.
- dtack_n  in  1  data acknowledge, active low, synchronous to clk_in.
- berr_n  in  1  bus error, active low, synchronous to clk_in.

Behaviour:
- Reset (reset==0 at a clock edge):
  - Next state is IDLE.
  - as_n=uds_n=lds_n=1, rw=1, d_oe=0, a_out=0, d_out=0, rdata=0, busy=0, done=0, err=0, tmo=0, wait counter 0.
  - Reset mid-cycle negates all strobes and d_oe on that same edge; no done pulse is produced.
- FSM states: IDLE, ADDR, ASRT, WAIT, LATCH, END. All outputs are registered.
- IDLE:
  - Accepts a request when req=1, req_be!=00, dtack_n=1 and berr_n=1 (responder released).
  - req with be=00 is ignored.
  - On accept: capture rw/addr/be/wdata, set busy=1, go to ADDR.
- ADDR (1 cycle):
  - a_out and rw driven; strobes high.
  - Write: d_out=wdata, d_oe=1.
- ASRT (1 cycle):
  - as_n=0.
  - Read: the selected uds_n/lds_n go low here.
  - Write: data strobes stay high.
- WAIT:
  - as_n=0; selected data strobes low for both reads and writes.
  - Each cycle samples dtack_n, berr_n and the counter.
  - berr_n=0 has priority: go to END with err=1, tmo=0 (simultaneous DTACK is ignored).
  - Else dtack_n=0: go to LATCH.
  - Else counter==TIMEOUT-1: go to END with err=1, tmo=1.
  - Else increment the counter. The counter clears on entry to WAIT.
- LATCH (1 cycle):
  - Strobes stay asserted.
  - Read: rdata<=d_in; unselected byte lanes of rdata keep their previous value.
  - Go to END.
- END (1 cycle):
  - as_n=uds_n=lds_n=1; d_oe stays 1 for writes (data hold).
  - done=1 with err/tmo.
  - On the next edge: busy=0, d_oe=0, rw=1, then IDLE.
- Errored reads do not update rdata.
- Latency, zero-wait DTACK: accept edge T → ADDR T+1 → ASRT T+2 → WAIT T+3 (DTACK seen) → LATCH T+4 → END/done T+5.
- Back-to-back requests:
  - Earliest next accept is the cycle after END.
  - A responder holding DTACK low stalls acceptance until it releases.
- req is ignored while busy.
- err/tmo hold their last values until the next done.

Test Plan:
- Reset: hold reset=0 for 3 cycles with req=1 → as_n=uds_n=lds_n=1, d_oe=0, busy=0, no done; release → request accepted next edge.
- Word read, zero wait: req_rw=1, addr=0x000100, be=11, dtack_n=0 during WAIT, d_in=0xBEEF → as_n low T+2..T+4, uds_n/lds_n low T+2..T+4, done at T+5, rdata=0xBEEF, err=0.
- Byte write, 3 wait states: rw=0, be=01, wdata=0x0055, dtack_n low on the 4th WAIT cycle → lds_n low from WAIT entry, uds_n stays high, d_oe=1 ADDR..END, d_out=0x0055, done err=0.
- Bus error with simultaneous DTACK: read, berr_n=0 and dtack_n=0 in first WAIT → END next edge, err=1, tmo=0, rdata unchanged.
- Timeout: read, dtack_n=berr_n=1 forever, TIMEOUT=64 → exactly 64 WAIT cycles, then done with err=1, tmo=1, strobes negated.
- Stuck DTACK / mid-cycle reset:
  - Hold dtack_n=0 after END with req=1 → no accept until dtack_n=1.
  - Separately, reset=0 during WAIT → strobes high on that same edge, busy=0, no done.
